// File: rtl/battleship_turn_ctrl.sv
// Battleship game sequencer: placement for both players, alternating fire turns,
// and game over. Every board access uses one shared request/acknowledge port.
module battleship_turn_ctrl #(
  parameter int GRID_N = 9,
  parameter int SHIPS  = 5,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             place_pulse,
  input  logic             fire_pulse,
  input  logic [3:0]       sel_row,
  input  logic [3:0]       sel_col,
  output logic             gr_req,
  output logic             gr_we,
  output logic             gr_board,
  output logic [3:0]       gr_row,
  output logic [3:0]       gr_col,
  output logic [1:0]       gr_wdata,
  input  logic [1:0]       gr_rdata,
  input  logic             gr_ack,
  output logic [1:0]       phase,
  output logic             active_player,
  output logic             busy,
  output logic [CNT_W-1:0] p1_ships,
  output logic [CNT_W-1:0] p2_ships,
  output logic [CNT_W-1:0] p1_hits,
  output logic [CNT_W-1:0] p2_hits,
  output logic [1:0]       winner
);

  localparam logic [2:0] S_IDLE_PLACE  = 3'd0;
  localparam logic [2:0] S_IDLE_BATTLE = 3'd1;
  localparam logic [2:0] S_RD          = 3'd2;
  localparam logic [2:0] S_DECIDE      = 3'd3;
  localparam logic [2:0] S_WR          = 3'd4;
  localparam logic [2:0] S_OVER        = 3'd5;

  localparam logic [1:0] PH_PLACE  = 2'd0;
  localparam logic [1:0] PH_BATTLE = 2'd1;
  localparam logic [1:0] PH_OVER   = 2'd2;

  localparam logic [1:0] C_EMPTY = 2'b00;
  localparam logic [1:0] C_SHIP  = 2'b01;
  localparam logic [1:0] C_MISS  = 2'b10;
  localparam logic [1:0] C_HIT   = 2'b11;

  localparam logic [CNT_W-1:0] LP_SHIPS = CNT_W'(SHIPS);

  logic [2:0]       r_state;
  logic [1:0]       r_phase;
  logic             r_active;
  logic             r_req;
  logic             r_we;
  logic             r_board;
  logic [3:0]       r_row;
  logic [3:0]       r_col;
  logic [1:0]       r_wdata;
  logic [1:0]       r_rdata;
  logic [CNT_W-1:0] r_p1_ships;
  logic [CNT_W-1:0] r_p2_ships;
  logic [CNT_W-1:0] r_p1_hits;
  logic [CNT_W-1:0] r_p2_hits;
  logic [1:0]       r_winner;

  logic             w_in_range;
  logic [CNT_W-1:0] w_ships_next;
  logic [CNT_W-1:0] w_hits_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= LP_SHIPS) ? LP_SHIPS : v + 1'b1;
  endfunction

  assign w_in_range   = (32'(sel_row) < GRID_N) && (32'(sel_col) < GRID_N);
  assign w_ships_next = sat_inc(r_active ? r_p2_ships : r_p1_ships);
  assign w_hits_next  = sat_inc(r_active ? r_p2_hits : r_p1_hits);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE_PLACE;
      r_phase    <= PH_PLACE;
      r_active   <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_board    <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_p1_ships <= '0;
      r_p2_ships <= '0;
      r_p1_hits  <= '0;
      r_p2_hits  <= '0;
      r_winner   <= '0;
    end else begin
      case (r_state)
        S_IDLE_PLACE: if (place_pulse && w_in_range) begin
          r_req   <= 1'b1;
          r_we    <= 1'b0;
          r_board <= r_active;
          r_row   <= sel_row;
          r_col   <= sel_col;
          r_state <= S_RD;
        end
        S_IDLE_BATTLE: if (fire_pulse && w_in_range) begin
          r_req   <= 1'b1;
          r_we    <= 1'b0;
          r_board <= ~r_active;
          r_row   <= sel_row;
          r_col   <= sel_col;
          r_state <= S_RD;
        end
        S_RD: if (gr_ack) begin
          r_req   <= 1'b0;
          r_rdata <= gr_rdata;
          r_state <= S_DECIDE;
        end
        S_DECIDE: begin
          // Occupied/already-shot cells end the sequence with no write and no turn change
          if (r_phase == PH_PLACE) begin
            if (r_rdata == C_EMPTY) begin
              r_req   <= 1'b1;
              r_we    <= 1'b1;
              r_wdata <= C_SHIP;
              r_state <= S_WR;
            end else begin
              r_state <= S_IDLE_PLACE;
            end
          end else if (r_rdata == C_SHIP || r_rdata == C_EMPTY) begin
            r_req   <= 1'b1;
            r_we    <= 1'b1;
            r_wdata <= (r_rdata == C_SHIP) ? C_HIT : C_MISS;
            r_state <= S_WR;
          end else begin
            r_state <= S_IDLE_BATTLE;
          end
        end
        S_WR: if (gr_ack) begin
          r_req <= 1'b0;
          r_we  <= 1'b0;
          if (r_phase == PH_PLACE) begin
            if (r_active) r_p2_ships <= w_ships_next;
            else          r_p1_ships <= w_ships_next;
            if (w_ships_next == LP_SHIPS && r_active) begin
              r_phase  <= PH_BATTLE;
              r_active <= 1'b0;
              r_state  <= S_IDLE_BATTLE;
            end else begin
              if (w_ships_next == LP_SHIPS) r_active <= 1'b1;
              r_state <= S_IDLE_PLACE;
            end
          end else if (r_wdata == C_HIT) begin
            if (r_active) r_p2_hits <= w_hits_next;
            else          r_p1_hits <= w_hits_next;
            if (w_hits_next == LP_SHIPS) begin
              r_phase  <= PH_OVER;
              r_winner <= r_active ? 2'b10 : 2'b01;
              r_state  <= S_OVER;
            end else begin
              r_active <= ~r_active;
              r_state  <= S_IDLE_BATTLE;
            end
          end else begin
            r_active <= ~r_active;
            r_state  <= S_IDLE_BATTLE;
          end
        end
        S_OVER: r_state <= S_OVER;
        default: r_state <= S_IDLE_PLACE;
      endcase
    end
  end

  assign gr_req        = r_req;
  assign gr_we         = r_we;
  assign gr_board      = r_board;
  assign gr_row        = r_row;
  assign gr_col        = r_col;
  assign gr_wdata      = r_wdata;
  assign phase         = r_phase;
  assign active_player = r_active;
  assign busy          = (r_state == S_RD) || (r_state == S_DECIDE) || (r_state == S_WR);
  assign p1_ships      = r_p1_ships;
  assign p2_ships      = r_p2_ships;
  assign p1_hits       = r_p1_hits;
  assign p2_hits       = r_p2_hits;
  assign winner        = r_winner;

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Directed bench for battleship_turn_ctrl with a board memory model that acks requests.
module tb_battleship_turn_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       place_pulse = 1'b0;
  logic       fire_pulse = 1'b0;
  logic [3:0] sel_row = '0;
  logic [3:0] sel_col = '0;
  logic       gr_req, gr_we, gr_board, gr_ack;
  logic [3:0] gr_row, gr_col;
  logic [1:0] gr_wdata, gr_rdata;
  logic [1:0] phase, winner;
  logic       active_player, busy;
  logic [3:0] p1_ships, p2_ships, p1_hits, p2_hits;

  logic       stall_rd = 1'b0;
  logic       stall_wr = 1'b0;
  logic [1:0] mem [0:161] = '{default: 2'b00};
  int         nwr = 0;
  int         nreq = 0;
  logic       last_board;
  logic [3:0] last_row, last_col;
  logic [1:0] last_data;
  int         nchk = 0;
  int         nerr = 0;

  battleship_turn_ctrl #(.GRID_N(9), .SHIPS(5), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .place_pulse(place_pulse), .fire_pulse(fire_pulse),
    .sel_row(sel_row), .sel_col(sel_col), .gr_req(gr_req), .gr_we(gr_we),
    .gr_board(gr_board), .gr_row(gr_row), .gr_col(gr_col), .gr_wdata(gr_wdata),
    .gr_rdata(gr_rdata), .gr_ack(gr_ack), .phase(phase), .active_player(active_player),
    .busy(busy), .p1_ships(p1_ships), .p2_ships(p2_ships), .p1_hits(p1_hits),
    .p2_hits(p2_hits), .winner(winner)
  );

  always #5 clk = ~clk;

  function automatic int cell_idx(input logic b, input logic [3:0] r, input logic [3:0] c);
    return (b ? 81 : 0) + ((r < 9) ? int'(r) : 0) * 9 + ((c < 9) ? int'(c) : 0);
  endfunction

  assign gr_ack   = gr_req && !(gr_we ? stall_wr : stall_rd);
  assign gr_rdata = mem[cell_idx(gr_board, gr_row, gr_col)];

  always @(posedge clk) begin
    if (gr_req) nreq++;
    if (gr_req && gr_ack && gr_we) begin
      nwr++;
      last_board = gr_board;
      last_row   = gr_row;
      last_col   = gr_col;
      last_data  = gr_wdata;
      mem[cell_idx(gr_board, gr_row, gr_col)] <= gr_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one pulse, then count cycles busy stays high (bounded).
  task automatic access(input bit fire, input logic [3:0] r, input logic [3:0] c, output int n);
    @(posedge clk); #1;
    sel_row = r; sel_col = c;
    if (fire) fire_pulse = 1'b1; else place_pulse = 1'b1;
    @(posedge clk); #1;
    fire_pulse = 1'b0; place_pulse = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n, w0, q0;
    logic stable;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_phase", 32'(phase), 0);
    chk("rst_ctl", {gr_req, gr_we, gr_board, busy, active_player}, 0);
    chk("rst_addr", {gr_row, gr_col, gr_wdata}, 0);
    chk("rst_cnt", {p1_ships, p2_ships, p1_hits, p2_hits, winner}, 0);
    reset = 1'b0;

    // P1 placement with a repeat on an occupied cell
    access(0, 0, 0, n);
    chk("place_busy3", 32'(n), 3);
    chk("place_wr0", {last_board, last_row, last_col, last_data}, {1'b0, 4'd0, 4'd0, 2'b01});
    w0 = nwr;
    access(0, 0, 0, n);
    chk("dup_busy2", 32'(n), 2);
    chk("dup_nowr", 32'(nwr - w0), 0);
    chk("dup_ships", 32'(p1_ships), 1);
    for (int i = 1; i < 5; i++) access(0, 0, 4'(i), n);
    chk("p1_ships5", 32'(p1_ships), 5);
    chk("p1_wrcnt", 32'(nwr), 5);
    chk("p1_lastwr", {last_board, last_row, last_col, last_data}, {1'b0, 4'd0, 4'd4, 2'b01});
    chk("p1_done", {phase, active_player}, {2'd0, 1'b1});

    for (int i = 0; i < 5; i++) access(0, 1, 4'(i), n);
    chk("p2_ships5", 32'(p2_ships), 5);
    chk("p2_board", {last_board, last_data}, {1'b1, 2'b01});
    chk("battle_start", {phase, active_player}, {2'd1, 1'b0});

    // place_pulse is ignored in battle
    q0 = nreq;
    access(0, 2, 2, n);
    chk("place_in_battle", 32'(nreq - q0), 0);

    access(1, 3, 3, n);
    chk("fire_miss_busy", 32'(n), 3);
    chk("fire_miss_wr", {last_board, last_row, last_col, last_data}, {1'b1, 4'd3, 4'd3, 2'b10});
    chk("turn_p2", 32'(active_player), 1);

    // P2 shot with read ack held low; cursor moves and a stray fire pulse arrive meanwhile
    stall_rd = 1'b1;
    @(posedge clk); #1;
    sel_row = 5; sel_col = 0; fire_pulse = 1'b1;
    @(posedge clk); #1;
    fire_pulse = 1'b0;
    stable = 1'b1;
    q0 = nreq;
    for (int k = 0; k < 10; k++) begin
      sel_col = 4'(k + 1);
      fire_pulse = (k == 3);
      stable &= (gr_req === 1'b1) && (gr_we === 1'b0) && (gr_board === 1'b0)
              && (gr_row === 4'd5) && (gr_col === 4'd0) && (busy === 1'b1);
      @(posedge clk); #1;
    end
    fire_pulse = 1'b0;
    chk("stall_stable", 32'(stable), 1);
    chk("stall_req_cycles", 32'(nreq - q0), 10);
    w0 = nwr;
    stall_rd = 1'b0;
    n = 0;
    while (busy && n < 40) begin n++; @(posedge clk); #1; end
    chk("stall_release", 32'(n), 3);
    chk("stall_wr", {last_board, last_row, last_col, last_data}, {1'b0, 4'd5, 4'd0, 2'b10});
    chk("stall_onewr", 32'(nwr - w0), 1);
    q0 = nreq;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_pulse_dropped", 32'(nreq - q0), 0);
    chk("turn_p1", 32'(active_player), 0);

    // repeat shot on a MISS cell is a free retry
    w0 = nwr;
    access(1, 3, 3, n);
    chk("retry_busy2", 32'(n), 2);
    chk("retry_turn", {32'(nwr - w0), 32'(active_player)}, 0);

    for (int i = 0; i < 5; i++) begin
      access(1, 1, 4'(i), n);
      if (i < 4) access(1, 5, 4'(i + 1), n);
    end
    chk("last_hit_wr", {last_board, last_row, last_col, last_data}, {1'b1, 4'd1, 4'd4, 2'b11});
    chk("p1_hits5", 32'(p1_hits), 5);
    chk("p2_hits0", 32'(p2_hits), 0);
    chk("game_over", {phase, winner, active_player}, {2'd2, 2'b01, 1'b0});
    q0 = nreq;
    access(1, 2, 2, n);
    access(0, 2, 2, n);
    chk("over_ignores", 32'(nreq - q0), 0);
    chk("over_hold", {phase, winner, p1_hits}, {2'd2, 2'b01, 4'd5});

    // new game, then reset while a write is outstanding
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_game", {phase, winner, p1_hits, p1_ships, p2_ships}, 0);
    access(0, 2, 2, n);
    chk("newgame_ship", 32'(p1_ships), 1);
    stall_wr = 1'b1;
    @(posedge clk); #1;
    sel_row = 2; sel_col = 3; place_pulse = 1'b1;
    @(posedge clk); #1;
    place_pulse = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("in_wr", {gr_req, gr_we, busy, gr_wdata}, {1'b1, 1'b1, 1'b1, 2'b01});
    #2;
    reset = 1'b1;
    #1;
    chk("async_drop", {gr_req, gr_we, busy}, 0);
    chk("async_cnt", {p1_ships, p2_ships, phase, active_player}, 0);
    stall_wr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    q0 = nreq;
    access(0, 9, 0, n);
    access(0, 0, 9, n);
    repeat (2) @(posedge clk);
    #1;
    chk("out_of_range", 32'(nreq - q0), 0);
    chk("oor_state", {busy, p1_ships}, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
